// File: rtl/lcd_pkg.sv
// Shared definitions for the character-LCD bus logic.
//  - HD44780-style command bytes used during power-on init and mode switches
//  - IDLE_DATA: the bus word driven in every cycle that carries no write
//  - lcd_state_e: states of the mode arbiter FSM
package lcd_pkg;

  localparam logic [7:0] CMD_FUNC_SET = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
  localparam logic [7:0] CMD_DISP_ON  = 8'h0C;  // display on, cursor off
  localparam logic [7:0] CMD_ENTRY    = 8'h06;  // increment, no shift
  localparam logic [7:0] CMD_CLEAR    = 8'h01;
  localparam logic [7:0] IDLE_DATA    = 8'h02;

  typedef enum logic [2:0] {
    StWait,
    StInit,
    StClrw,
    StGrant,
    StSwitch
  } lcd_state_e;

endpackage

// File: rtl/lcd_init_rom.sv
// LCD power-on init command table (combinational).
// Ports:
//   idx  in  2  position in the init sequence (0..3)
//   cmd  out 8  command byte for that position
module lcd_init_rom
  import lcd_pkg::*;
(
  input  logic [1:0] idx,
  output logic [7:0] cmd
);

  always_comb begin
    unique case (idx)
      2'd0:    cmd = CMD_FUNC_SET;
      2'd1:    cmd = CMD_DISP_ON;
      2'd2:    cmd = CMD_ENTRY;
      default: cmd = CMD_CLEAR;
    endcase
  end

endmodule

// File: rtl/lcd_mode_arbiter.sv
// Owns the shared character-LCD bus and time-shares it between the clock's mode modules.
// Runs the power-on init, grants the bus to the requester selected by MODE and registers
// that requester's RW/RS/DATA onto the pins. A mode change is honoured at the next frame
// boundary with a display clear before the new owner is granted.
// Ports:
//   CLK       in   1        system clock
//   RESET     in   1        synchronous, active-high reset
//   MODE      in   4        selected requester; values >= N_REQ mean no owner
//   REQ_RW    in   N_REQ    per-requester RW
//   REQ_RS    in   N_REQ    per-requester RS
//   REQ_DATA  in   8*N_REQ  per-requester data, [8k+7:8k] = requester k
//   EN        out  N_REQ    one-hot grant
//   LCD_RW    out  1        LCD read/write pin
//   LCD_RS    out  1        LCD register select
//   LCD_DATA  out  8        LCD data bus
//   LCD_E     out  1        LCD enable strobe
//   BUSY      out  1        high in every state except GRANT
module lcd_mode_arbiter
  import lcd_pkg::*;
#(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned INIT_WAIT = 30,
  parameter int unsigned CLR_WAIT  = 2,
  parameter int unsigned FRAME_LEN = 36
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [3:0]         MODE,
  input  logic [N_REQ-1:0]   REQ_RW,
  input  logic [N_REQ-1:0]   REQ_RS,
  input  logic [8*N_REQ-1:0] REQ_DATA,
  output logic [N_REQ-1:0]   EN,
  output logic               LCD_RW,
  output logic               LCD_RS,
  output logic [7:0]         LCD_DATA,
  output logic               LCD_E,
  output logic               BUSY
);

  localparam int unsigned WAIT_MAX = (INIT_WAIT > CLR_WAIT) ? INIT_WAIT : CLR_WAIT;
  localparam int unsigned WAIT_W   = $clog2(WAIT_MAX + 1);
  localparam int unsigned FRAME_W  = $clog2(FRAME_LEN);

  lcd_state_e         state_q, state_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [1:0]         idx_q, idx_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic [3:0]         sel_q, sel_d;
  logic               rw_q, rw_d;
  logic               rs_q, rs_d;
  logic [7:0]         data_q, data_d;
  logic               e_q, e_d;

  logic       pend;
  logic       req_valid;
  logic       req_rw;
  logic       req_rs;
  logic [7:0] req_data;
  logic [7:0] init_cmd;

  lcd_init_rom u_init_rom (
    .idx (idx_d),
    .cmd (init_cmd)
  );

  // Requester mux; full 4-bit compare so out-of-range MODE never aliases a valid index.
  always_comb begin
    req_valid = 1'b0;
    req_rw    = 1'b1;
    req_rs    = 1'b1;
    req_data  = IDLE_DATA;
    for (int k = 0; k < N_REQ; k++) begin
      if (sel_q == 4'(k)) begin
        req_valid = 1'b1;
        req_rw    = REQ_RW[k];
        req_rs    = REQ_RS[k];
        req_data  = REQ_DATA[8*k +: 8];
      end
    end
  end

  // Always reflects the latest MODE sample, so changing back before the boundary cancels.
  assign pend = (MODE != sel_q);

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    idx_d   = idx_q;
    frame_d = frame_q;
    sel_d   = sel_q;
    case (state_q)
      StWait: begin
        if (wait_q == WAIT_W'(INIT_WAIT - 1)) begin
          state_d = StInit;
          wait_d  = '0;
          idx_d   = '0;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      StInit: begin
        if (idx_q == 2'd3) begin
          state_d = StClrw;
          wait_d  = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      StClrw: begin
        if (wait_q == WAIT_W'(CLR_WAIT - 1)) begin
          state_d = StGrant;
          wait_d  = '0;
          frame_d = '0;
          sel_d   = MODE;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      StGrant: begin
        if (frame_q == FRAME_W'(FRAME_LEN - 1)) begin
          frame_d = '0;
          if (pend) begin
            state_d = StSwitch;
          end
        end else begin
          frame_d = frame_q + 1'b1;
        end
      end
      StSwitch: begin
        state_d = StClrw;
        wait_d  = '0;
        frame_d = '0;
      end
      default: state_d = StWait;
    endcase
  end

  // Pin word for the coming cycle, decoded from the state being entered. Requester data is
  // only forwarded once the grant is already established, giving the one-cycle latency.
  always_comb begin
    rw_d   = 1'b1;
    rs_d   = 1'b1;
    data_d = IDLE_DATA;
    e_d    = 1'b0;
    case (state_d)
      StInit: begin
        rw_d   = 1'b0;
        rs_d   = 1'b0;
        data_d = init_cmd;
        e_d    = 1'b1;
      end
      StSwitch: begin
        rw_d   = 1'b0;
        rs_d   = 1'b0;
        data_d = CMD_CLEAR;
        e_d    = 1'b1;
      end
      StGrant: begin
        if (state_q == StGrant && req_valid) begin
          rw_d   = req_rw;
          rs_d   = req_rs;
          data_d = req_data;
          e_d    = ~req_rw;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= StWait;
      wait_q  <= '0;
      idx_q   <= '0;
      frame_q <= '0;
      sel_q   <= '0;
      rw_q    <= 1'b1;
      rs_q    <= 1'b1;
      data_q  <= IDLE_DATA;
      e_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      idx_q   <= idx_d;
      frame_q <= frame_d;
      sel_q   <= sel_d;
      rw_q    <= rw_d;
      rs_q    <= rs_d;
      data_q  <= data_d;
      e_q     <= e_d;
    end
  end

  always_comb begin
    EN = '0;
    if (state_q == StGrant) begin
      for (int k = 0; k < N_REQ; k++) begin
        if (sel_q == 4'(k)) begin
          EN[k] = 1'b1;
        end
      end
    end
  end

  assign BUSY     = (state_q != StGrant);
  assign LCD_RW   = rw_q;
  assign LCD_RS   = rs_q;
  assign LCD_DATA = data_q;
  assign LCD_E    = e_q;

endmodule

// File: tb/tb_lcd_mode_arbiter.sv
// Directed bench for lcd_mode_arbiter. Observed bus word is packed as
// {EN[3:0], LCD_RW, LCD_RS, LCD_DATA[7:0], LCD_E, BUSY}.
module tb_lcd_mode_arbiter;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [3:0]  MODE;
  logic [3:0]  REQ_RW;
  logic [3:0]  REQ_RS;
  logic [31:0] REQ_DATA;
  logic [3:0]  EN;
  logic        LCD_RW;
  logic        LCD_RS;
  logic [7:0]  LCD_DATA;
  logic        LCD_E;
  logic        BUSY;

  int checks = 0;
  int fails  = 0;
  int fpos   = 0;  // bench's own frame position while granted

  lcd_mode_arbiter #(
    .N_REQ     (4),
    .INIT_WAIT (30),
    .CLR_WAIT  (2),
    .FRAME_LEN (36)
  ) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .MODE     (MODE),
    .REQ_RW   (REQ_RW),
    .REQ_RS   (REQ_RS),
    .REQ_DATA (REQ_DATA),
    .EN       (EN),
    .LCD_RW   (LCD_RW),
    .LCD_RS   (LCD_RS),
    .LCD_DATA (LCD_DATA),
    .LCD_E    (LCD_E),
    .BUSY     (BUSY)
  );

  always #5 CLK = ~CLK;

  function automatic logic [15:0] obs();
    return {EN, LCD_RW, LCD_RS, LCD_DATA, LCD_E, BUSY};
  endfunction

  function automatic logic [15:0] word(input logic [3:0] en, input logic rw, input logic rs,
                                       input logic [7:0] data, input logic e, input logic busy);
    return {en, rw, rs, data, e, busy};
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
    fpos = (fpos == 35) ? 0 : fpos + 1;
  endtask

  task automatic idle_reqs();
    REQ_RW   = 4'hF;
    REQ_RS   = 4'hF;
    REQ_DATA = {4{8'h02}};
  endtask

  task automatic test_reset();
    logic [7:0] cmds [4];
    cmds[0] = 8'h38; cmds[1] = 8'h0C; cmds[2] = 8'h06; cmds[3] = 8'h01;
    RESET = 1'b1;
    MODE  = 4'd0;
    idle_reqs();
    tick();
    tick();
    RESET = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (i > 0) tick();
      if (obs() !== word(4'b0000, 1'b1, 1'b1, 8'h02, 1'b0, 1'b1)) begin
        fails++;
        $display("FAIL reset_idle[%0d]: got %h want %h", i, obs(),
                 word(4'b0000, 1'b1, 1'b1, 8'h02, 1'b0, 1'b1));
      end
      checks++;
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      if (obs() !== word(4'b0000, 1'b0, 1'b0, cmds[i], 1'b1, 1'b1)) begin
        fails++;
        $display("FAIL init_cmd[%0d]: got %h want %h", i, obs(),
                 word(4'b0000, 1'b0, 1'b0, cmds[i], 1'b1, 1'b1));
      end
      checks++;
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      if (obs() !== word(4'b0000, 1'b1, 1'b1, 8'h02, 1'b0, 1'b1)) begin
        fails++;
        $display("FAIL init_clrw[%0d]: got %h want %h", i, obs(),
                 word(4'b0000, 1'b1, 1'b1, 8'h02, 1'b0, 1'b1));
      end
      checks++;
    end
    tick();
    fpos = 0;
    if (obs() !== word(4'b0001, 1'b1, 1'b1, 8'h02, 1'b0, 1'b0)) begin
      fails++;
      $display("FAIL first_grant: got %h want %h", obs(),
               word(4'b0001, 1'b1, 1'b1, 8'h02, 1'b0, 1'b0));
    end
    checks++;
  endtask

  // MODE leaves and returns to 0 inside one frame: grant never interrupted, no clear.
  task automatic test_cancel();
    for (int i = 0; i < 45; i++) begin
      if (i == 5)  MODE = 4'd1;
      if (i == 15) MODE = 4'd0;
      tick();
      if (obs() !== word(4'b0001, 1'b1, 1'b1, 8'h02, 1'b0, 1'b0)) begin
        fails++;
        $display("FAIL cancel[%0d]: got %h want %h", i, obs(),
                 word(4'b0001, 1'b1, 1'b1, 8'h02, 1'b0, 1'b0));
      end
      checks++;
    end
  endtask

  task automatic test_switch();
    while (fpos != 10) tick();
    MODE = 4'd2;
    while (fpos != 35) begin
      tick();
      if (obs() !== word(4'b0001, 1'b1, 1'b1, 8'h02, 1'b0, 1'b0)) begin
        fails++;
        $display("FAIL switch_hold[%0d]: got %h want %h", fpos, obs(),
                 word(4'b0001, 1'b1, 1'b1, 8'h02, 1'b0, 1'b0));
      end
      checks++;
    end
    tick();
    if (obs() !== word(4'b0000, 1'b0, 1'b0, 8'h01, 1'b1, 1'b1)) begin
      fails++;
      $display("FAIL switch_clear: got %h want %h", obs(),
               word(4'b0000, 1'b0, 1'b0, 8'h01, 1'b1, 1'b1));
    end
    checks++;
    for (int i = 0; i < 2; i++) begin
      tick();
      if (obs() !== word(4'b0000, 1'b1, 1'b1, 8'h02, 1'b0, 1'b1)) begin
        fails++;
        $display("FAIL switch_clrw[%0d]: got %h want %h", i, obs(),
                 word(4'b0000, 1'b1, 1'b1, 8'h02, 1'b0, 1'b1));
      end
      checks++;
    end
    tick();
    fpos = 0;
    if (obs() !== word(4'b0100, 1'b1, 1'b1, 8'h02, 1'b0, 1'b0)) begin
      fails++;
      $display("FAIL switch_grant: got %h want %h", obs(),
               word(4'b0100, 1'b1, 1'b1, 8'h02, 1'b0, 1'b0));
    end
    checks++;
  endtask

  task automatic test_data_path();
    MODE = 4'd1;
    while (fpos != 35) tick();
    tick();
    tick();
    tick();
    tick();
    fpos = 0;
    // Requester 0 also drives a write; only requester 1 may reach the pins.
    REQ_DATA = {8'h02, 8'h02, 8'h41, 8'hAA};
    REQ_RS   = 4'b1111;
    REQ_RW   = 4'b1100;
    tick();
    if (obs() !== word(4'b0010, 1'b0, 1'b1, 8'h41, 1'b1, 1'b0)) begin
      fails++;
      $display("FAIL data_write: got %h want %h", obs(),
               word(4'b0010, 1'b0, 1'b1, 8'h41, 1'b1, 1'b0));
    end
    checks++;
    REQ_RW[1]        = 1'b1;
    REQ_RS[1]        = 1'b0;
    REQ_DATA[15:8]   = 8'h55;
    tick();
    if (obs() !== word(4'b0010, 1'b1, 1'b0, 8'h55, 1'b0, 1'b0)) begin
      fails++;
      $display("FAIL data_read_no_e: got %h want %h", obs(),
               word(4'b0010, 1'b1, 1'b0, 8'h55, 1'b0, 1'b0));
    end
    checks++;
    REQ_RW[1]      = 1'b0;
    REQ_DATA[15:8] = 8'h80;
    tick();
    if (obs() !== word(4'b0010, 1'b0, 1'b0, 8'h80, 1'b1, 1'b0)) begin
      fails++;
      $display("FAIL data_cmd: got %h want %h", obs(),
               word(4'b0010, 1'b0, 1'b0, 8'h80, 1'b1, 1'b0));
    end
    checks++;
    idle_reqs();
    tick();
    if (obs() !== word(4'b0010, 1'b1, 1'b1, 8'h02, 1'b0, 1'b0)) begin
      fails++;
      $display("FAIL data_idle: got %h want %h", obs(),
               word(4'b0010, 1'b1, 1'b1, 8'h02, 1'b0, 1'b0));
    end
    checks++;
  endtask

  task automatic test_invalid_mode();
    MODE = 4'hF;
    while (fpos != 35) tick();
    tick();
    if (obs() !== word(4'b0000, 1'b0, 1'b0, 8'h01, 1'b1, 1'b1)) begin
      fails++;
      $display("FAIL inv_clear: got %h want %h", obs(),
               word(4'b0000, 1'b0, 1'b0, 8'h01, 1'b1, 1'b1));
    end
    checks++;
    tick();
    tick();
    tick();
    fpos = 0;
    REQ_RW   = 4'h0;
    REQ_DATA = {4{8'h77}};
    for (int i = 0; i < 6; i++) begin
      if (obs() !== word(4'b0000, 1'b1, 1'b1, 8'h02, 1'b0, 1'b0)) begin
        fails++;
        $display("FAIL inv_grant[%0d]: got %h want %h", i, obs(),
                 word(4'b0000, 1'b1, 1'b1, 8'h02, 1'b0, 1'b0));
      end
      checks++;
      tick();
    end
    idle_reqs();
    MODE = 4'd1;
    while (fpos != 35) tick();
    tick();
    if (obs() !== word(4'b0000, 1'b0, 1'b0, 8'h01, 1'b1, 1'b1)) begin
      fails++;
      $display("FAIL inv_exit_clear: got %h want %h", obs(),
               word(4'b0000, 1'b0, 1'b0, 8'h01, 1'b1, 1'b1));
    end
    checks++;
    tick();
    tick();
    tick();
    fpos = 0;
    if (obs() !== word(4'b0010, 1'b1, 1'b1, 8'h02, 1'b0, 1'b0)) begin
      fails++;
      $display("FAIL inv_exit_grant: got %h want %h", obs(),
               word(4'b0010, 1'b1, 1'b1, 8'h02, 1'b0, 1'b0));
    end
    checks++;
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] cmds [4];
    cmds[0] = 8'h38; cmds[1] = 8'h0C; cmds[2] = 8'h06; cmds[3] = 8'h01;
    while (fpos != 20) tick();
    RESET = 1'b1;
    MODE  = 4'd3;
    tick();
    RESET = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (i > 0) tick();
      if (obs() !== word(4'b0000, 1'b1, 1'b1, 8'h02, 1'b0, 1'b1)) begin
        fails++;
        $display("FAIL midrst_idle[%0d]: got %h want %h", i, obs(),
                 word(4'b0000, 1'b1, 1'b1, 8'h02, 1'b0, 1'b1));
      end
      checks++;
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      if (obs() !== word(4'b0000, 1'b0, 1'b0, cmds[i], 1'b1, 1'b1)) begin
        fails++;
        $display("FAIL midrst_init[%0d]: got %h want %h", i, obs(),
                 word(4'b0000, 1'b0, 1'b0, cmds[i], 1'b1, 1'b1));
      end
      checks++;
    end
    tick();
    tick();
    tick();
    if (obs() !== word(4'b1000, 1'b1, 1'b1, 8'h02, 1'b0, 1'b0)) begin
      fails++;
      $display("FAIL midrst_grant: got %h want %h", obs(),
               word(4'b1000, 1'b1, 1'b1, 8'h02, 1'b0, 1'b0));
    end
    checks++;
  endtask

  initial begin
    test_reset();
    test_cancel();
    test_switch();
    test_data_path();
    test_invalid_mode();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
